// File: rtl/alu_sequencer.sv
// alu_sequencer: front-end controller for the combinational ALU.
// Accepts two operand beats (A then B) over a valid/ready stream, registers them
// onto the ALU inputs, captures the ALU result and flags one cycle later, and
// presents the captured result on a valid/ready output stream.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand stream handshake
//   in_data, in_op           operand (A first, B second), opcode (B beat only)
//   in_invalid               invalid-data marker, OR-combined across both beats
//   alu_in1/2, alu_op        registered operands/opcode driven to the ALU
//   alu_invalid_data         registered invalid flag driven to the ALU
//   alu_out/zero/error       combinational ALU result and flags
//   res_valid/res_ready      result stream handshake
//   res_data/zero/error      captured ALU result and flags
//   busy                     high whenever the sequencer is not idle
//   err_count                saturating count of delivered error results
module alu_sequencer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [1:0]         in_op,
   input  logic               in_invalid,
   output logic [WIDTH-1:0]   alu_in1,
   output logic [WIDTH-1:0]   alu_in2,
   output logic [1:0]         alu_op,
   output logic               alu_invalid_data,
   input  logic [2*WIDTH-1:0] alu_out,
   input  logic               alu_zero,
   input  logic               alu_error,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [2*WIDTH-1:0] res_data,
   output logic               res_zero,
   output logic               res_error,
   output logic               busy,
   output logic [7:0]         err_count
);

   typedef enum logic [1:0] {
      StIdle,
      StWaitB,
      StExec,
      StDone
   } state_e;

   state_e             state_q, state_d;
   logic               inv_a_q, inv_a_d;
   logic [WIDTH-1:0]   alu_in1_q, alu_in1_d;
   logic [WIDTH-1:0]   alu_in2_q, alu_in2_d;
   logic [1:0]         alu_op_q, alu_op_d;
   logic               alu_inv_q, alu_inv_d;
   logic [2*WIDTH-1:0] res_data_q, res_data_d;
   logic               res_zero_q, res_zero_d;
   logic               res_error_q, res_error_d;
   logic [7:0]         err_count_q, err_count_d;

   always_comb begin
      state_d     = state_q;
      inv_a_d     = inv_a_q;
      alu_in1_d   = alu_in1_q;
      alu_in2_d   = alu_in2_q;
      alu_op_d    = alu_op_q;
      alu_inv_d   = alu_inv_q;
      res_data_d  = res_data_q;
      res_zero_d  = res_zero_q;
      res_error_d = res_error_q;
      err_count_d = err_count_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               alu_in1_d = in_data;
               inv_a_d   = in_invalid;
               state_d   = StWaitB;
            end
         end
         StWaitB: begin
            if (in_valid) begin
               alu_in2_d = in_data;
               alu_op_d  = in_op;
               alu_inv_d = inv_a_q | in_invalid;
               state_d   = StExec;
            end
         end
         StExec: begin
            // ALU inputs have been stable for the whole cycle; capture its outputs.
            res_data_d  = alu_out;
            res_zero_d  = alu_zero;
            res_error_d = alu_error;
            state_d     = StDone;
         end
         StDone: begin
            if (res_ready) begin
               if (res_error_q && (err_count_q != 8'hFF)) begin
                  err_count_d = err_count_q + 8'd1;
               end
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         inv_a_q     <= 1'b0;
         alu_in1_q   <= '0;
         alu_in2_q   <= '0;
         alu_op_q    <= 2'b00;
         alu_inv_q   <= 1'b0;
         res_data_q  <= '0;
         res_zero_q  <= 1'b0;
         res_error_q <= 1'b0;
         err_count_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         inv_a_q     <= inv_a_d;
         alu_in1_q   <= alu_in1_d;
         alu_in2_q   <= alu_in2_d;
         alu_op_q    <= alu_op_d;
         alu_inv_q   <= alu_inv_d;
         res_data_q  <= res_data_d;
         res_zero_q  <= res_zero_d;
         res_error_q <= res_error_d;
         err_count_q <= err_count_d;
      end
   end

   // Handshake outputs are pure decodes of the state register.
   assign in_ready         = (state_q == StIdle) || (state_q == StWaitB);
   assign res_valid        = (state_q == StDone);
   assign busy             = (state_q != StIdle);
   assign alu_in1          = alu_in1_q;
   assign alu_in2          = alu_in2_q;
   assign alu_op           = alu_op_q;
   assign alu_invalid_data = alu_inv_q;
   assign res_data         = res_data_q;
   assign res_zero         = res_zero_q;
   assign res_error        = res_error_q;
   assign err_count        = err_count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU model attached.
module tb_alu_sequencer;

   localparam int unsigned W = 8;

   logic            clk;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    in_data;
   logic [1:0]      in_op;
   logic            in_invalid;
   logic [W-1:0]    alu_in1;
   logic [W-1:0]    alu_in2;
   logic [1:0]      alu_op;
   logic            alu_invalid_data;
   logic [2*W-1:0]  alu_out;
   logic            alu_zero;
   logic            alu_error;
   logic            res_valid;
   logic            res_ready;
   logic [2*W-1:0]  res_data;
   logic            res_zero;
   logic            res_error;
   logic            busy;
   logic [7:0]      err_count;

   int n_cmp = 0;
   int n_err = 0;

   alu_sequencer #(.WIDTH(W)) dut (
      .clk              (clk),
      .rst              (rst),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_data          (in_data),
      .in_op            (in_op),
      .in_invalid       (in_invalid),
      .alu_in1          (alu_in1),
      .alu_in2          (alu_in2),
      .alu_op           (alu_op),
      .alu_invalid_data (alu_invalid_data),
      .alu_out          (alu_out),
      .alu_zero         (alu_zero),
      .alu_error        (alu_error),
      .res_valid        (res_valid),
      .res_ready        (res_ready),
      .res_data         (res_data),
      .res_zero         (res_zero),
      .res_error        (res_error),
      .busy             (busy),
      .err_count        (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural combinational ALU: signed ops sign-extended to 2*W, errors -> all-ones.
   logic signed [2*W-1:0] sa, sb, sr;
   always_comb begin
      sa = {{W{alu_in1[W-1]}}, alu_in1};
      sb = {{W{alu_in2[W-1]}}, alu_in2};
      sr = '0;
      alu_error = alu_invalid_data || (alu_op == 2'b11 && alu_in2 == '0);
      case (alu_op)
         2'b00:   sr = sa + sb;
         2'b01:   sr = sa - sb;
         2'b10:   sr = sa * sb;
         default: sr = (alu_in2 == '0) ? '0 : sa / sb;
      endcase
      alu_out  = alu_error ? '1 : sr;
      alu_zero = !alu_error && (alu_out == '0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".in_ready"}, in_ready, 1);
      chk({tag, ".res_valid"}, res_valid, 0);
      chk({tag, ".busy"}, busy, 0);
      chk({tag, ".alu_in1"}, alu_in1, 0);
      chk({tag, ".alu_in2"}, alu_in2, 0);
      chk({tag, ".alu_op"}, alu_op, 0);
      chk({tag, ".alu_inv"}, alu_invalid_data, 0);
      chk({tag, ".res_data"}, res_data, 0);
      chk({tag, ".res_zero"}, res_zero, 0);
      chk({tag, ".res_error"}, res_error, 0);
      chk({tag, ".err_count"}, err_count, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents A then B on consecutive cycles; returns with the DUT in EXEC.
   // in_op carries a junk value on the A beat to show it is only sampled on B.
   task automatic load_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                          input logic ia, input logic ib);
      in_valid = 1'b1; in_data = a; in_op = ~op; in_invalid = ia;
      tick();
      in_data = b; in_op = op; in_invalid = ib;
      tick();
      in_valid = 1'b0; in_data = '0; in_op = 2'b00; in_invalid = 1'b0;
   endtask

   task automatic handshake();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_op = '0; in_invalid = 1'b0;
      res_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk_reset("reset");

      // 5 + 3
      in_valid = 1'b1; in_data = 8'd5; in_op = 2'b11; in_invalid = 1'b0;
      tick();
      chk("add.waitb_busy", busy, 1);
      chk("add.waitb_ready", in_ready, 1);
      chk("add.a_loaded", alu_in1, 8'd5);
      in_data = 8'd3; in_op = 2'b00;
      tick();
      in_valid = 1'b0;
      chk("add.exec_ready", in_ready, 0);
      chk("add.exec_valid", res_valid, 0);
      chk("add.b_loaded", alu_in2, 8'd3);
      chk("add.op_loaded", alu_op, 2'b00);
      tick();
      chk("add.res_valid_3cyc", res_valid, 1);
      chk("add.res_data", res_data, 16'h0008);
      chk("add.res_zero", res_zero, 0);
      chk("add.res_error", res_error, 0);
      handshake();
      chk("add.back_idle", busy, 0);

      // 3 - 5, then -4 * 3
      load_op(8'd3, 8'd5, 2'b01, 1'b0, 1'b0);
      tick();
      chk("sub.res_data", res_data, 16'hFFFE);
      handshake();
      load_op(8'hFC, 8'd3, 2'b10, 1'b0, 1'b0);
      tick();
      chk("mul.res_data", res_data, 16'hFFF4);
      chk("mul.res_error", res_error, 0);
      handshake();

      // Divide by zero and err_count saturation
      load_op(8'd7, 8'd0, 2'b11, 1'b0, 1'b0);
      tick();
      chk("div0.res_error", res_error, 1);
      chk("div0.res_data", res_data, 16'hFFFF);
      chk("div0.res_zero", res_zero, 0);
      chk("div0.cnt_before_hs", err_count, 0);
      handshake();
      chk("div0.err_count", err_count, 1);
      for (int i = 1; i < 300; i++) begin
         load_op(8'd7, 8'd0, 2'b11, 1'b0, 1'b0);
         tick();
         handshake();
         if (i == 253) chk("div0.err_count_254", err_count, 254);
      end
      chk("div0.err_count_sat", err_count, 255);

      // Invalid flag on A only, OR-combined into alu_invalid_data
      load_op(8'd7, 8'd7, 2'b01, 1'b1, 1'b0);
      chk("inv.alu_invalid", alu_invalid_data, 1);
      tick();
      chk("inv.res_error", res_error, 1);
      chk("inv.res_data", res_data, 16'hFFFF);
      handshake();
      chk("inv.err_count_held", err_count, 255);
      // Clean 7 - 7
      load_op(8'd7, 8'd7, 2'b01, 1'b0, 1'b0);
      chk("clean.alu_invalid", alu_invalid_data, 0);
      tick();
      chk("clean.res_zero", res_zero, 1);
      chk("clean.res_data", res_data, 0);
      chk("clean.res_error", res_error, 0);
      handshake();

      // Stall in DONE with in_valid high
      load_op(8'd5, 8'd3, 2'b00, 1'b0, 1'b0);
      tick();
      in_valid = 1'b1; in_data = 8'h55; in_op = 2'b10;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("stall.in_ready", in_ready, 0);
         chk("stall.res_valid", res_valid, 1);
         chk("stall.res_data", res_data, 16'h0008);
         chk("stall.alu_in1", alu_in1, 8'd5);
      end
      in_valid = 1'b0;
      handshake();
      chk("stall.idle_ready", in_ready, 1);
      chk("stall.idle_valid", res_valid, 0);
      chk("stall.alu_in1_hold", alu_in1, 8'd5);

      // Clear counter, then reset during EXEC
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_reset("rst_idle");
      load_op(8'd9, 8'd4, 2'b10, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_reset("rst_exec");

      // Reset during WAIT_B
      in_valid = 1'b1; in_data = 8'd6; in_invalid = 1'b1;
      tick();
      in_valid = 1'b0; in_invalid = 1'b0;
      chk("rst_waitb.pre_busy", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_reset("rst_waitb");

      // Reset in DONE with an error result and res_ready high: counter must stay 0
      load_op(8'd7, 8'd0, 2'b11, 1'b0, 1'b0);
      tick();
      chk("rst_done.pre_valid", res_valid, 1);
      rst = 1'b1; res_ready = 1'b1;
      tick();
      rst = 1'b0; res_ready = 1'b0;
      chk_reset("rst_done");

      // res_ready while idle has no effect
      res_ready = 1'b1;
      tick();
      tick();
      res_ready = 1'b0;
      chk("idle_rdy.busy", busy, 0);
      chk("idle_rdy.res_valid", res_valid, 0);

      // Fresh A after resets
      load_op(8'd2, 8'd9, 2'b00, 1'b0, 1'b0);
      chk("fresh.alu_in1", alu_in1, 8'd2);
      chk("fresh.alu_inv", alu_invalid_data, 0);
      tick();
      chk("fresh.res_data", res_data, 16'h000B);
      handshake();
      chk("fresh.err_count", err_count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
